// File: rtl/parity_frame_checker_pkg.sv
// Constants shared by the serial parity receiver: FSM state encodings,
// parity sense values and the parity mismatch rule.
package parity_frame_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam bit PARITY_SENSE_EVEN = 1'b0;
    localparam bit PARITY_SENSE_ODD  = 1'b1;

    // High when the received parity bit disagrees with the accumulated data parity.
    function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic odd);
        return acc ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter: advances by one per inc_i pulse and sticks at all-ones.
module parity_frame_checker_sat_counter
    import parity_frame_checker_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: reassembles DATA_W data bits (LSB first), checks the
// trailing parity bit and counts errored frames.
module parity_frame_checker
    import parity_frame_checker_pkg::*;
#(
    parameter int unsigned DATA_W     = 4,
    parameter bit          PARITY_ODD = PARITY_SENSE_EVEN,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_err,
    output logic                 frame_done,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic             SENSE    = PARITY_ODD ? PARITY_SENSE_ODD : PARITY_SENSE_EVEN;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    count_q;
    logic                acc_q;
    logic                err_q;
    logic                done_q;
    logic                busy_q;
    logic                par_accept;
    logic                frame_err;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals; a missing
        // branch assignment would otherwise infer a latch.
        par_accept = 1'b0;
        frame_err  = 1'b0;
        if ((state_q == ST_PAR) && bit_valid && !frame_start) begin
            par_accept = 1'b1;
            frame_err  = parity_mismatch(acc_q, serial_in, SENSE);
        end
    end

    // frame_start has priority in every state: it starts or aborts-and-restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is reset as well, so a frame cut short by
            // reset can never leak stale bits into a later data word.
            state_q <= ST_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (frame_start) begin
                state_q <= ST_DATA;
                busy_q  <= 1'b1;
                shift_q <= '0;
                count_q <= '0;
                acc_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_DATA: begin
                        if (bit_valid) begin
                            for (int i = 0; i < int'(DATA_W); i++) begin
                                if (count_q == CNT_W'(i)) shift_q[i] <= serial_in;
                            end
                            acc_q   <= acc_q ^ serial_in;
                            count_q <= count_q + CNT_W'(1);
                            if (count_q == LAST_IDX) state_q <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        if (bit_valid) begin
                            data_q  <= shift_q;
                            err_q   <= frame_err;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    parity_frame_checker_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (par_accept & frame_err),
        .count_o (err_count)
    );

    assign data_out   = data_q;
    assign parity_err = err_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule
